seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_shift_reg.sv | 45 ++++
 rtl/seq_pattern_gen.sv | 135 +++++++++++++
 tb/tb_seq_pattern_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the 101 sequence detectors:
// FSM state encoding, ASCII state names and the default pattern width.
package seq_pkg;

    localparam int unsigned SEQ_PAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam logic [31:0] NAME_IDLE = "IDLE";
    localparam logic [31:0] NAME_SHFT = "SHFT";
    localparam logic [31:0] NAME_DONE = "DONE";
    localparam logic [31:0] NAME_UNKN = "????";

    function automatic logic [31:0] state_name_of(input seq_state_t s);
        case (s)
            ST_IDLE:  state_name_of = NAME_IDLE;
            ST_SHIFT: state_name_of = NAME_SHFT;
            ST_DONE:  state_name_of = NAME_DONE;
            default:  state_name_of = NAME_UNKN;
        endcase
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register; keeps a latched, left-aligned copy of the
// pattern so each new pass can reload it without touching the live input.
module seq_shift_reg
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned SH_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic [SH_W-1:0]  align,
    output logic             msb
);

    logic [PAT_W-1:0] sr;
    logic [PAT_W-1:0] pat_lat;
    logic [PAT_W-1:0] aligned;

    // Left-align so pattern bit len-1 lands in the MSB; bits above len fall off the top.
    assign aligned = pattern << align;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr      <= '0;
            pat_lat <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr      <= aligned;
            pat_lat <= aligned;
        end else if (reload) begin
            sr <= pat_lat;
        end else if (shift) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = sr[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits len pattern bits MSB-first, rep passes back to back.
// Define SEQ_PATTERN_GEN_STATE_NAME_EN to add the ASCII state_name debug output.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       rep,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
`ifdef SEQ_PATTERN_GEN_STATE_NAME_EN
    ,
    output logic [31:0]      state_name
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [3:0]       pass_cnt;
    logic             start_ok;
    logic             pass_end;
    logic             last_bit;
    logic             sr_load;
    logic             sr_reload;
    logic             sr_shift;
    logic             sr_clear;

    assign len_c    = (len > LEN_MAX) ? LEN_MAX : len;
    assign start_ok = (len_c != '0) && (rep != '0);
    assign pass_end = (bit_cnt == '0);
    assign last_bit = pass_end && (pass_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = start_ok ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_SHIFT) || (state == ST_DONE);
        done      = (state == ST_DONE);
        x_valid   = (state == ST_SHIFT);
        sr_load   = 1'b0;
        sr_reload = 1'b0;
        sr_shift  = 1'b0;
        sr_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sr_load  = start_ok;
                    sr_clear = !start_ok;
                end
            end
            ST_SHIFT: begin
                if (!pass_end)            sr_shift  = 1'b1;
                else if (pass_cnt != '0)  sr_reload = 1'b1;
                else                      sr_clear  = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters hold remaining bits/passes and are only decremented when non-zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q    <= '0;
            bit_cnt  <= '0;
            pass_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len_c;
                        bit_cnt  <= start_ok ? len_c - 1'b1 : '0;
                        pass_cnt <= start_ok ? rep - 4'd1 : '0;
                    end
                end
                ST_SHIFT: begin
                    if (!pass_end) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (pass_cnt != '0) begin
                        bit_cnt  <= len_q - 1'b1;
                        pass_cnt <= pass_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .SH_W  (LEN_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sr_load),
        .reload  (sr_reload),
        .shift   (sr_shift),
        .clear   (sr_clear),
        .pattern (pattern),
        .align   (LEN_MAX - len_c),
        .msb     (x)
    );

`ifdef SEQ_PATTERN_GEN_STATE_NAME_EN
    assign state_name = state_name_of(state);
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed self-checking bench for seq_pattern_gen (PAT_W=8).
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
`ifdef SEQ_PATTERN_GEN_STATE_NAME_EN
    logic [31:0] state_name;
`endif

    int checks   = 0;
    int failures = 0;

    seq_pattern_gen #(
        .PAT_W (8),
        .LEN_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .rep     (rep),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
`ifdef SEQ_PATTERN_GEN_STATE_NAME_EN
        ,
        .state_name (state_name)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {x, x_valid, busy, done}
    task automatic chk_out(input string tag, input logic [3:0] exp);
        check(tag, 32'({x, x_valid, busy, done}), 32'(exp));
    endtask

    // Samples n consecutive cycles; returns the bits MSB-first and how many lacked x_valid.
    task automatic collect(input int n, output logic [15:0] bits, output int not_valid);
        bits = '0;
        not_valid = 0;
        for (int i = 0; i < n; i++) begin
            bits = {bits[14:0], x};
            if (x_valid !== 1'b1) not_valid++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        logic [5:0]  stream6;
        logic [7:0]  exp_pat;
        int          nv;
        int          hits;
        int          vcount;
        int          bad;
        int          done_seen;

        rst = 1'b0; start = 1'b1; pattern = 8'hFF; len = 4'd8; rep = 4'd1;
        tick(); tick();
        chk_out("reset_outputs", 4'b0000);
        rst = 1'b1; start = 1'b0;
        tick();
        chk_out("idle_after_reset", 4'b0000);

        // Single pass 101
        pattern = 8'b0000_0101; len = 4'd3; rep = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("single_bit0", 4'b1110);
        tick(); chk_out("single_bit1", 4'b0110);
        tick(); chk_out("single_bit2", 4'b1110);
        tick(); chk_out("single_done", 4'b0011);
        tick(); chk_out("single_idle", 4'b0000);

        // Two passes of 101 -> 101101, two detector hits
        pattern = 8'b0000_0101; len = 4'd3; rep = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        collect(6, bits, nv);
        stream6 = bits[5:0];
        check("rep2_stream", 32'(stream6), 32'h2D);
        check("rep2_valid", 32'(nv), 32'd0);
        hits = 0;
        for (int i = 0; i <= 3; i++) if (stream6[i +: 3] == 3'b101) hits++;
        check("rep2_det_hits", 32'(hits), 32'd2);
        chk_out("rep2_done", 4'b0011);
        tick(); chk_out("rep2_idle", 4'b0000);

        // Degenerate len=0 / rep=0
        pattern = 8'hFF; len = 4'd0; rep = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("len0_done", 4'b0011);
        tick(); chk_out("len0_idle", 4'b0000);
        pattern = 8'h07; len = 4'd3; rep = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("rep0_done", 4'b0011);
        tick(); chk_out("rep0_idle", 4'b0000);

        // Abort during the 2nd bit of A5
        pattern = 8'hA5; len = 4'd8; rep = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("abort_bit0", 4'b1110);
        tick(); chk_out("abort_bit1", 4'b0110);
        rst = 1'b0;
        tick(); chk_out("abort_cleared", 4'b0000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("abort_no_done", 4'b0000);
        end
        start = 1'b1;
        tick(); start = 1'b0;
        collect(8, bits, nv);
        check("abort_retx_bits", 32'(bits[7:0]), 32'hA5);
        check("abort_retx_valid", 32'(nv), 32'd0);
        chk_out("abort_retx_done", 4'b0011);
        tick(); chk_out("abort_retx_idle", 4'b0000);

        // Inputs disturbed mid-transmission
        pattern = 8'hC3; len = 4'd8; rep = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        bits = '0; nv = 0;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[14:0], x};
            if (x_valid !== 1'b1) nv++;
            if (i == 2) begin start = 1'b1; pattern = 8'h00; len = 4'd2; rep = 4'd5; end
            if (i == 3) start = 1'b0;
            tick();
        end
        check("robust_bits", 32'(bits[7:0]), 32'hC3);
        check("robust_valid", 32'(nv), 32'd0);
        chk_out("robust_done", 4'b0011);
        tick(); chk_out("robust_idle", 4'b0000);

        // len=12 clamps to 8
        pattern = 8'h96; len = 4'd12; rep = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        collect(8, bits, nv);
        check("clamp_bits", 32'(bits[7:0]), 32'h96);
        check("clamp_valid", 32'(nv), 32'd0);
        chk_out("clamp_done", 4'b0011);
        tick(); chk_out("clamp_idle", 4'b0000);

        // rep=15, len=8 -> 120 bits
        exp_pat = 8'h5A;
        pattern = exp_pat; len = 4'd8; rep = 4'd15; start = 1'b1;
        tick(); start = 1'b0;
        vcount = 0; bad = 0; done_seen = 0;
        for (int i = 0; i < 200 && done_seen == 0; i++) begin
            if (x_valid === 1'b1) begin
                if (x !== exp_pat[7 - (vcount % 8)]) bad++;
                vcount++;
            end
            if (done === 1'b1) done_seen = 1;
            else tick();
        end
        check("long_valid_count", 32'(vcount), 32'd120);
        check("long_bit_errors", 32'(bad), 32'd0);
        check("long_done_seen", 32'(done_seen), 32'd1);
        chk_out("long_done", 4'b0011);
        tick(); chk_out("long_idle", 4'b0000);

        // start held high: one idle cycle between transmissions
        pattern = 8'h02; len = 4'd2; rep = 4'd1; start = 1'b1;
        tick(); chk_out("held_a_bit0", 4'b1110);
        tick(); chk_out("held_a_bit1", 4'b0110);
        tick(); chk_out("held_a_done", 4'b0011);
        tick(); chk_out("held_gap", 4'b0000);
        tick(); chk_out("held_b_bit0", 4'b1110);
        start = 1'b0;
        tick(); chk_out("held_b_bit1", 4'b0110);
        tick(); chk_out("held_b_done", 4'b0011);
        tick(); chk_out("held_b_idle", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
